// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-wise block copy over a single-port memory interface.
// Each byte takes a READ cycle (address = source, capture data) followed by
// a WRITE cycle (address = destination, strobe write enable).
module mem_copy_engine #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write_enable,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] dst_ptr_d;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] remaining_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [DATA_W-1:0] buffer;
    logic [DATA_W-1:0] buffer_d;
    logic              busy_d;
    logic              done_d;
    logic              write_enable_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_next    = state;
        src_ptr_d     = src_ptr;
        dst_ptr_d     = dst_ptr;
        remaining_d   = remaining;
        buffer_d      = buffer;
        mem_address_d = mem_address;

        case (state)
            IDLE: begin
                if (start) begin
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = length;
                    state_next  = (length == ADDR_W'(0)) ? DONE : READ;
                end
            end
            READ: begin
                buffer_d   = mem_data_in;
                src_ptr_d  = src_ptr + ADDR_W'(1);
                state_next = WRITE;
            end
            WRITE: begin
                dst_ptr_d   = dst_ptr + ADDR_W'(1);
                remaining_d = remaining - ADDR_W'(1);
                state_next  = (remaining == ADDR_W'(1)) ? DONE : READ;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Address follows the pointer owned by the upcoming state; holds otherwise
        if (state_next == READ) begin
            mem_address_d = src_ptr_d;
        end else if (state_next == WRITE) begin
            mem_address_d = dst_ptr_d;
        end

        busy_d         = (state_next == READ) || (state_next == WRITE);
        done_d         = (state_next == DONE);
        write_enable_d = (state_next == WRITE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr          <= '0;
            dst_ptr          <= '0;
            remaining        <= '0;
            buffer           <= '0;
            mem_address      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            mem_write_enable <= 1'b0;
        end else begin
            src_ptr          <= src_ptr_d;
            dst_ptr          <= dst_ptr_d;
            remaining        <= remaining_d;
            buffer           <= buffer_d;
            mem_address      <= mem_address_d;
            busy             <= busy_d;
            done             <= done_d;
            mem_write_enable <= write_enable_d;
        end
    end

    // Write data is always the captured byte
    assign mem_data_out = buffer;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: memory model, reference copy model and
// write scoreboard with an independent monitor.
module tb_mem_copy_engine;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic [DATA_W-1:0] mem_data_in;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_write_enable;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    logic              tb_wr;
    logic [ADDR_W-1:0] tb_waddr;
    logic [DATA_W-1:0] tb_wdata;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  pending_done = 0;
    int  total = 0;
    int  bad = 0;

    mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .mem_data_in      (mem_data_in),
        .mem_address      (mem_address),
        .mem_data_out     (mem_data_out),
        .mem_write_enable (mem_write_enable),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // 256x8 memory: combinational read, write on rising edge
    assign mem_data_in = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_data_out;
        else if (tb_wr)       mem[tb_waddr]    <= tb_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next scoreboard entry
    always @(negedge clk) begin
        wr_t e;
        if (mem_write_enable) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue",
                         mem_address, mem_data_out);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_address), 32'(e.addr));
                check("wr_data", 32'(mem_data_out), 32'(e.data));
            end
        end
        if (done) begin
            total++;
            if (pending_done == 0) begin
                bad++;
                $display("FAIL spurious_done: done=1 expected no pending copy");
            end else begin
                pending_done--;
            end
        end
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        tb_wr    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_wr    = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic verify_mem();
        for (int i = 0; i < int'(DEPTH); i++)
            if (mem[i] !== ref_mem[i]) check($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
            else total++;
    endtask

    // Reference: forward byte-by-byte copy, pointers modulo 256
    task automatic model_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n);
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        for (int i = 0; i < n; i++) begin
            a = s + ADDR_W'(i);
            b = d + ADDR_W'(i);
            ref_mem[b] = ref_mem[a];
            exp_wr.push_back('{addr: b, data: ref_mem[a]});
        end
    endtask

    task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [ADDR_W-1:0] l, input bit glitch);
        int n;
        int busy_cnt;
        int we_cnt;
        int done_at;
        n = int'(l);
        busy_cnt = 0;
        we_cnt = 0;
        done_at = 0;
        model_copy(s, d, n);
        pending_done++;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(negedge clk);
        start = 1'b0;
        src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom); length = ADDR_W'($urandom);
        for (int c = 1; c <= 600; c++) begin
            if (c > 1) @(negedge clk);
            if (glitch && c == 3) begin
                start = 1'b1;
                src_addr = s + 8'd7; dst_addr = d + 8'd9; length = ADDR_W'($urandom_range(1, 20));
            end else begin
                start = 1'b0;
            end
            busy_cnt += int'(busy);
            we_cnt   += int'(mem_write_enable);
            if (done) begin
                done_at = c;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_cycle", 32'(done_at), 32'(2 * n + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(2 * n));
        check("we_cycles", 32'(we_cnt), 32'(n));
        check("done_pulse_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("scoreboard_drained", 32'(exp_wr.size()), 32'd0);
        verify_mem();
    endtask

    initial begin
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rl;
        reset = 1'b1; start = 1'b0; tb_wr = 1'b0;
        tb_waddr = '0; tb_wdata = '0;
        src_addr = '0; dst_addr = '0; length = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_data_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) poke(ADDR_W'(i), DATA_W'($urandom));

        // Basic 4-byte copy
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        run_copy(8'h10, 8'h80, 8'd4, 1'b0);
        check("basic_last_byte", 32'(mem[8'h83]), 32'hD4);

        // Source straddles the top of memory
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
        run_copy(8'hFE, 8'h01, 8'd3, 1'b0);
        check("wrap_byte2", 32'(mem[8'h03]), 32'h33);

        // Zero length
        run_copy(8'h55, 8'h66, 8'd0, 1'b0);

        // Overlap dst = src + 1 replicates the first byte
        poke(8'h20, 8'h5A);
        run_copy(8'h20, 8'h21, 8'd5, 1'b0);
        check("overlap_last", 32'(mem[8'h25]), 32'h5A);

        // src == dst
        run_copy(8'h70, 8'h70, 8'd3, 1'b0);

        // start re-pulsed mid-copy is ignored
        run_copy(8'h30, 8'hC0, 8'd6, 1'b1);

        // Reset during the WRITE of byte 2 of a 4-byte copy
        poke(8'h92, ~ref_mem[8'h42]);
        model_copy(8'h40, 8'h90, 2);
        @(negedge clk);
        start = 1'b1; src_addr = 8'h40; dst_addr = 8'h90; length = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check("we_before_reset", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_we", 32'(mem_write_enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_addr", 32'(mem_address), 32'd0);
        check("arst_wdata", 32'(mem_data_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("arst_scoreboard", 32'(exp_wr.size()), 32'd0);
        verify_mem();
        run_copy(8'h40, 8'h90, 8'd4, 1'b0);

        // Randomized copies
        for (int k = 0; k < 14; k++) begin
            rs = ADDR_W'($urandom);
            rd = ADDR_W'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 255))
                                             : ADDR_W'($urandom_range(0, 12));
            run_copy(rs, rd, rl, (rl >= 8'd2) && ($urandom_range(0, 1) == 1));
        end

        check("no_pending_done", 32'(pending_done), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator for the 256×8 `data_memory` port. It drives `address`/`data_in`/`write_enable` and samples the combinational `data_out` to move `length` bytes from `src_addr` to `dst_addr`, one byte per two cycles. The block sits beside the CPU datapath. While `busy` is high, the top-level mux gives this block ownership of the memory port.

## Interface
Parameters:
- `ADDR_W`, 8, address width; memory depth is 2^ADDR_W, and pointers wrap modulo that depth
- `DATA_W`, 8, byte width

Ports:
- `clk`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-high; one clock domain, async assert
- `start`  in  1  request pulse; sampled only in IDLE
- `src_addr`  in  ADDR_W  first source address; latched on accepted start
- `dst_addr`  in  ADDR_W  first destination address; latched on accepted start
- `length`  in  ADDR_W  byte count, 0..255; 0 means no transfer
- `mem_data_in`  in  DATA_W  from memory `data_out`, combinational read
- `mem_address`  out  ADDR_W  to memory `address`
- `mem_data_out`  out  DATA_W  to memory `data_in`
- `mem_write_enable`  out  1  to memory `write_enable`
- `busy`  out  1  high in READ and WRITE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, READ, WRITE, DONE. State and pointers are registered. Outputs are decoded from state and registers.
- IDLE:
  - `start` is high at an edge: latch `src_ptr=src_addr`, `dst_ptr=dst_addr`, `remaining=length`.
  - Next state is READ, or DONE if `length==0`.
- READ:
  - `mem_address=src_ptr`, `mem_write_enable=0`.
  - At the edge: `buffer<=mem_data_in`, `src_ptr<=src_ptr+1` (mod 2^ADDR_W), next state is WRITE.
- WRITE:
  - `mem_address=dst_ptr`, `mem_data_out=buffer`, `mem_write_enable=1`.
  - At the edge: the memory commits, `dst_ptr<=dst_ptr+1`, `remaining<=remaining-1`.
  - Next state is DONE if `remaining==1`, else READ.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `mem_write_enable` is high only in WRITE. `mem_data_out` holds `buffer` at all times.
- In IDLE and DONE, `mem_address` holds the last driven value. The port is not owned in those states.
- `start` in any state other than IDLE is ignored. It is not queued.
- Wrap-around: pointers roll 255→0 silently. A copy may straddle the top of memory.
- Overlap: strictly forward, byte by byte, each read following the previous write.
  - `dst == src+1` with N bytes replicates `mem[src]` into all N destinations. This is the defined behaviour.
  - `src == dst` rewrites identical data.
- Reset (async, any state including mid-copy):
  - Next state is IDLE immediately.
  - `mem_write_enable=0`, `busy=0`, `done=0`, `mem_address=0`, `mem_data_out=0`, `buffer=0`, pointers and `remaining` = 0.
  - An in-flight write is abandoned. Bytes already written stay written.

## Timing
- Accepted `start` at edge t0: `busy` rises after t0.
- Byte k (0-based) is read in the cycle after edge t0+2k and written at edge t0+2k+2.
- N-byte copy: `busy` is high for 2N cycles. `done` is high in the cycle between edges t0+2N and t0+2N+1. The next `start` is accepted at edge t0+2N+2 or later.
- `length==0`: no memory writes, `busy` never rises, `done` is high in the cycle after t0.
- Read data path: `mem_address` valid → `mem_data_in` combinational → captured at the same cycle's edge. No wait states.
- Max copy (255 bytes): 510 busy cycles.

## Test plan
- Preload `mem[0x10..0x13]={0xA1,0xB2,0xC3,0xD4}`, start with src=0x10, dst=0x80, len=4 → `mem[0x80..0x83]` matches, `busy` high 8 cycles, single `done` pulse, `write_enable` high exactly 4 cycles.
- src=0xFE, dst=0x01, len=3 with `mem[0xFE,0xFF,0x00]={0x11,0x22,0x33}` → `mem[0x01..0x03]={0x11,0x22,0x33}`; verifies pointer wrap.
- len=0 → no write strobes, `busy` stays 0, `done` pulse one cycle after start.
- Overlap: `mem[0x20]=0x5A`, src=0x20, dst=0x21, len=5 → `mem[0x21..0x25]` all 0x5A.
- `start` re-pulsed mid-copy with different args → ignored; the original copy completes unchanged and `done` fires once.
- Assert `reset` during WRITE of byte 2 of a 4-byte copy → `mem_write_enable` drops without waiting for an edge, outputs go to reset values, byte 2 is not written, bytes 0–1 are intact, and a fresh copy after release works.
